divider: RTL and testbench

Iterative 32-bit integer divider for the execute stage, the inverse companion of the combinational multiplier. Implements RV32M DIV, DIVU, REM and REMU as a radix-2 restoring divider, one quotient bit per cycle. It stalls the pipeline through a start/busy/done handshake and returns either the quotient or the remainder on a 32-bit result bus.

---
 rtl/divider_pkg.sv | 38 +++
 rtl/div_step.sv | 27 ++
 rtl/divider.sv | 140 ++++++++++++++
 tb/tb_divider.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared FSM state type, ALU function codes and result select for the divider
//
// Contents:
//   div_state_t    IDLE / CALC / FIX / DONE
//   ALU_DIV/DIVU/REM/REMU  5-bit execute-stage function codes handled by the divider
//   is_signed_op   DIV and REM treat operands as two's complement
//   sel_result     picks quotient or remainder for the requested function
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic [4:0] ALU_DIV  = 5'h0c;
  localparam logic [4:0] ALU_DIVU = 5'h0d;
  localparam logic [4:0] ALU_REM  = 5'h0e;
  localparam logic [4:0] ALU_REMU = 5'h0f;

  function automatic logic is_signed_op(input logic [4:0] func);
    return (func == ALU_DIV) || (func == ALU_REM);
  endfunction

  function automatic logic [31:0] sel_result(input logic [4:0]  func,
                                             input logic [31:0] quot,
                                             input logic [31:0] rem);
    logic [31:0] res;
    case (func)
      ALU_DIV, ALU_DIVU: res = quot;
      ALU_REM, ALU_REMU: res = rem;
      default:           res = quot;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Ports:
//   rem_in        in  33  partial remainder before this iteration
//   dividend_bit  in  1   next dividend bit shifted into the remainder
//   divisor       in  32  divisor magnitude
//   rem_out       out 33  partial remainder after trial subtract / restore
//   q_bit         out 1   quotient bit produced by this iteration
module div_step (
  input  logic [32:0] rem_in,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);

  logic [33:0] shifted;
  logic [33:0] diff;

  // The restored remainder is always below the divisor, so the extra top
  // bit only guards the trial subtraction against wrap-around.
  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[33];
  assign rem_out = q_bit ? diff[32:0] : shifted[32:0];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - iterative radix-2 restoring 32-bit divider for DIV/DIVU/REM/REMU
//
// Ports:
//   clock           in  1   system clock, rising edge
//   reset_n         in  1   asynchronous active-low reset
//   start           in  1   launch a division (accepted in IDLE or DONE)
//   flush           in  1   abort any operation in flight; wins over start
//   opa             in  32  dividend, sampled on the start edge
//   opb             in  32  divisor, sampled on the start edge
//   ID_EX_alu_func  in  5   ALU_DIV / ALU_DIVU / ALU_REM / ALU_REMU
//   busy            out 1   high while in CALC or FIX
//   done            out 1   one-cycle pulse when div_res is valid
//   div_res         out 32  quotient or remainder, held until the next accepted start
module divider
  import divider_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [4:0]  ID_EX_alu_func,
  output logic        busy,
  output logic        done,
  output logic [31:0] div_res
);

  div_state_t  state;
  logic [4:0]  func_q;
  logic [31:0] dividend;     // shifts left each iteration; ends up holding the quotient
  logic [31:0] divisor_mag;
  logic [32:0] rem;
  logic [4:0]  cnt;
  logic        quot_neg;
  logic        rem_neg;

  logic        op_signed;
  logic        sa;
  logic        sb;
  logic        div_zero;
  logic        overflow;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic [32:0] step_rem;
  logic        step_q;

  always_comb begin
    op_signed = is_signed_op(ID_EX_alu_func);
    sa        = op_signed & opa[31];
    sb        = op_signed & opb[31];
    a_mag     = sa ? (~opa + 32'd1) : opa;
    b_mag     = sb ? (~opb + 32'd1) : opb;
    div_zero  = (opb == 32'h0);
    overflow  = op_signed && (opa == 32'h8000_0000) && (opb == 32'hFFFF_FFFF);
  end

  div_step u_step (
    .rem_in       (rem),
    .dividend_bit (dividend[31]),
    .divisor      (divisor_mag),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      func_q      <= 5'h0;
      dividend    <= 32'h0;
      divisor_mag <= 32'h0;
      rem         <= 33'h0;
      cnt         <= 5'h0;
      quot_neg    <= 1'b0;
      rem_neg     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_res     <= 32'h0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 5'h0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            func_q <= ID_EX_alu_func;
            if (div_zero) begin
              div_res <= sel_result(ID_EX_alu_func, 32'hFFFF_FFFF, opa);
              state   <= DONE;
              done    <= 1'b1;
            end else if (overflow) begin
              div_res <= sel_result(ID_EX_alu_func, 32'h8000_0000, 32'h0);
              state   <= DONE;
              done    <= 1'b1;
            end else begin
              dividend    <= a_mag;
              divisor_mag <= b_mag;
              quot_neg    <= sa ^ sb;
              rem_neg     <= sa;
              rem         <= 33'h0;
              cnt         <= 5'h0;
              state       <= CALC;
              busy        <= 1'b1;
            end
          end
        end

        CALC: begin
          rem      <= step_rem;
          dividend <= {dividend[30:0], step_q};
          cnt      <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= FIX;
          end
        end

        FIX: begin
          div_res <= sel_result(func_q,
                                quot_neg ? (~dividend + 32'd1) : dividend,
                                rem_neg ? (~rem[31:0] + 32'd1) : rem[31:0]);
          state   <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider with directed and random operations
module tb_divider;
  import divider_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        flush;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [4:0]  ID_EX_alu_func;
  logic        busy;
  logic        done;
  logic [31:0] div_res;

  int tests;
  int fails;

  divider dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .flush          (flush),
    .opa            (opa),
    .opb            (opb),
    .ID_EX_alu_func (ID_EX_alu_func),
    .busy           (busy),
    .done           (done),
    .div_res        (div_res)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference results from RV32M semantics using native arithmetic.
  function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    logic want_rem;
    logic sgn;
    int   sa;
    int   sb;
    want_rem = (f == ALU_REM) || (f == ALU_REMU);
    sgn      = (f == ALU_DIV) || (f == ALU_REM);
    if (b == 32'h0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return want_rem ? 32'h0 : 32'h8000_0000;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return want_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return want_rem ? (a % b) : (a / b);
  endfunction

  function automatic int model_latency(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (f == ALU_DIV) || (f == ALU_REM);
    if (b == 32'h0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Drive start for exactly one sampling edge, starting from the current time.
  task automatic start_now(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    start          = 1'b1;
    ID_EX_alu_func = f;
    opa            = a;
    opb            = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic start_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start_now(f, a, b);
  endtask

  // Returns at the negedge of the cycle where done is high; n = further edges waited.
  task automatic wait_done(output int n, output int busy_cycles, output logic timed_out);
    n           = 0;
    busy_cycles = 0;
    timed_out   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
      @(posedge clock);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    int          n;
    int          bc;
    logic        to;
    logic [31:0] exp_res;
    int          exp_lat;
    exp_res = model(f, a, b);
    exp_lat = model_latency(f, a, b);
    start_op(f, a, b);
    wait_done(n, bc, to);
    check({tag, "_timeout"}, 32'(to), 32'd0);
    check({tag, "_res"}, div_res, exp_res);
    check({tag, "_lat"}, 32'(n + 1), 32'(exp_lat));
    check({tag, "_busy"}, 32'(bc), (exp_lat == 1) ? 32'd0 : 32'd33);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, div_res, exp_res);
  endtask

  initial begin
    int          n;
    int          bc;
    int          cnt;
    logic        to;
    logic [4:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  funcs[4];

    tests          = 0;
    fails          = 0;
    reset_n        = 1'b0;
    start          = 1'b0;
    flush          = 1'b0;
    opa            = 32'h0;
    opb            = 32'h0;
    ID_EX_alu_func = ALU_DIVU;
    funcs[0] = ALU_DIV;
    funcs[1] = ALU_DIVU;
    funcs[2] = ALU_REM;
    funcs[3] = ALU_REMU;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_res", div_res, 32'h0);
    reset_n = 1'b1;

    // Directed cases
    run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7);
    run_op("remu_100_7", ALU_REMU, 32'd100, 32'd7);
    run_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("div_7_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_5_0", ALU_DIVU, 32'd5, 32'd0);
    run_op("remu_5_0", ALU_REMU, 32'd5, 32'd0);
    run_op("divu_ovf_pat", ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush at CALC iteration 10
    start_op(ALU_DIVU, 32'hDEAD_BEEF, 32'd3);
    repeat (10) @(posedge clock);
    #1 flush = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    start = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    check("flush_quiet", 32'(cnt), 32'd0);
    run_op("after_flush", ALU_DIVU, 32'd9, 32'd3);

    // Back-to-back: second start issued in the DONE cycle of the first
    start_op(ALU_DIVU, 32'd1000, 32'd10);
    wait_done(n, bc, to);
    check("b2b_first", div_res, 32'd100);
    start_now(ALU_REM, 32'hFFFF_FF9C, 32'd7);
    check("b2b_busy", 32'(busy), 32'd1);
    // A start while busy must be ignored
    repeat (5) @(posedge clock);
    #1 start_now(ALU_DIVU, 32'd50, 32'd5);
    wait_done(n, bc, to);
    check("b2b_timeout", 32'(to), 32'd0);
    check("b2b_second", div_res, model(ALU_REM, 32'hFFFF_FF9C, 32'd7));
    check("ignored_start_lat", 32'(n + 7), 32'd34);
    @(posedge clock);
    @(negedge clock);
    check("ignored_no_rerun", 32'(busy), 32'd0);
    check("ignored_hold", div_res, model(ALU_REM, 32'hFFFF_FF9C, 32'd7));

    // Asynchronous reset mid-CALC
    start_op(ALU_DIVU, 32'd12345, 32'd17);
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_done", 32'(done), 32'd0);
    check("areset_res", div_res, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) cnt++;
    end
    check("areset_no_done", 32'(cnt), 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      f = funcs[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: begin a = 32'($urandom_range(0, 20)); b = $urandom; end
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), f, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
